// File: rtl/sync_down_counter_ld_pkg.sv
// Shared types and defaults for the loadable down-counter.
// Optional prescaler is enabled with CNT_PRESCALE_EN.
package sync_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_e;

  localparam int CNT_WIDTH    = 4;
  localparam int CNT_PRESCALE = 4;

endpackage

// File: rtl/sync_down_counter_ld_if.sv
// Control/status bundle between a timer user and the down-counter.
// master drives the controls, slave is the counter.
interface sync_down_counter_ld_if
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output en,
    output load,
    output load_val,
    output auto_reload,
    input  count,
    input  tc,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  load,
    input  load_val,
    input  auto_reload,
    output count,
    output tc,
    output busy,
    output done
  );

endinterface

// File: rtl/sync_down_counter_ld_bit.sv
// One counter cell: D flop with load mux and borrow toggle.
// The chain ripples borrow from bit 0 upward.
module down_cnt_bit (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic ld_bit,
  input  logic dec,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ld_bit;
    end else if (dec && borrow_in) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = borrow_in & ~q_q;

endmodule

// File: rtl/sync_down_counter_ld.sv
// Loadable down-counter timer, one-shot or auto-reload.
// Define CNT_PRESCALE_EN to divide enabled cycles by PRESCALE.
module sync_down_counter_ld
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int PRESCALE = CNT_PRESCALE
) (
  input logic                  clk,
  input logic                  reset,
  sync_down_counter_ld_if.slave sif
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must be 2..16");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_ps
    $error("PRESCALE must be 2..256");
  end

  state_e           state_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ld_mux;
  logic [WIDTH:0]   borrow;
  logic             run;
  logic             tick;
  logic             dec;
  logic             reload;
  logic             cell_ld;
  logic             is_zero;
  logic             is_one;

  assign run = (state_q == RUN);

`ifdef CNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          wrap;

  assign wrap = (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (wrap) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (sif.load) begin
      pre_q <= '0;
    end else if (run && sif.en) begin
      pre_q <= pre_d;
    end
  end

  assign tick = run & sif.en & wrap;
`else
  assign tick = run & sif.en;
`endif

  // MSB borrow-out is high exactly when every bit is zero
  assign is_zero = borrow[WIDTH];
  assign is_one  = (cnt == WIDTH'(1));

  assign dec     = tick & ~is_zero;
  assign reload  = tick & is_zero & sif.auto_reload;
  assign cell_ld = sif.load | reload;
  assign ld_mux  = sif.load ? sif.load_val : reload_q;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    down_cnt_bit u_bit (
      .clk       (clk),
      .reset     (reset),
      .load      (cell_ld),
      .ld_bit    (ld_mux[i]),
      .dec       (dec),
      .borrow_in (borrow[i]),
      .q         (cnt[i]),
      .borrow_out(borrow[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (sif.load) begin
      reload_q <= sif.load_val;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      if (sif.load_val != '0) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      tc_q <= dec & is_one;
      unique case (state_q)
        RUN: begin
          // zero decision: one-shot reaching 0, or mode dropped at 0
          if (tick && (is_one || is_zero) && !sif.auto_reload) begin
            state_q <= EXPIRED;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sif.count = cnt;
  assign sif.tc    = tc_q;
  assign sif.busy  = busy_q;
  assign sif.done  = done_q;

endmodule

// File: tb/tb_sync_down_counter_ld.sv
// Randomised and directed bench for sync_down_counter_ld.
// Reference model tracks count, reload and mode as plain integers.
module tb_sync_down_counter_ld;

  localparam int W  = 4;
  localparam int PS = 4;
`ifdef CNT_PRESCALE_EN
  localparam int SF = PS;
`else
  localparam int SF = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  sync_down_counter_ld_if #(.WIDTH(W)) sif ();

  sync_down_counter_ld #(
    .WIDTH   (W),
    .PRESCALE(PS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int m_cnt;
  int m_rl;
  int m_ps;
  bit m_tc;
  bit m_run;
  bit m_exp;

  task automatic model_reset();
    m_cnt = 0;
    m_rl  = 0;
    m_ps  = 0;
    m_tc  = 0;
    m_run = 0;
    m_exp = 0;
  endtask

  task automatic model_edge(input bit e, input bit l,
                            input bit ar, input int lv);
    bit stepping;
    m_tc = 0;
    if (l) begin
      m_cnt = lv;
      m_rl  = lv;
      m_ps  = 0;
      m_run = (lv != 0);
      m_exp = 0;
    end else if (m_run && e) begin
`ifdef CNT_PRESCALE_EN
      stepping = (m_ps == PS - 1);
      m_ps     = stepping ? 0 : m_ps + 1;
`else
      stepping = 1;
`endif
      if (stepping) begin
        if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_tc = 1;
            if (!ar) begin
              m_run = 0;
              m_exp = 1;
            end
          end
        end else if (ar) begin
          m_cnt = m_rl;
        end else begin
          m_run = 0;
          m_exp = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit e, input bit l,
                       input bit ar, input int lv);
    sif.en          = e;
    sif.load        = l;
    sif.auto_reload = ar;
    sif.load_val    = W'(lv);
    @(posedge clk);
    model_edge(e, l, ar, lv % (1 << W));
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    sif.en          = 1'b0;
    sif.load        = 1'b0;
    sif.auto_reload = 1'b0;
    sif.load_val    = '0;
    model_reset();
    #3;
    vectors++;
    if (sif.count !== '0 || sif.tc !== 1'b0 ||
        sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: count=%0d tc=%b busy=%b done=%b want 0 0 0 0",
               sif.count, sif.tc, sif.busy, sif.done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 0);
      vectors++;
      if (sif.count !== '0 || sif.busy !== 1'b0 || sif.tc !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset: count=%0d busy=%b tc=%b want 0 0 0",
                 sif.count, sif.busy, sif.tc);
      end
    end
  endtask

  task automatic test_oneshot();
    drive(1'b0, 1'b1, 1'b0, 5);
    for (int i = 1; i <= 5 * SF + 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      vectors++;
      if (sif.count !== W'(m_cnt) || sif.tc !== m_tc ||
          sif.busy !== m_run || sif.done !== m_exp) begin
        miscompares++;
        $display("FAIL oneshot[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, sif.count, sif.tc, sif.busy, sif.done,
                 m_cnt, m_tc, m_run, m_exp);
      end
`ifndef CNT_PRESCALE_EN
      vectors++;
      if (sif.count !== W'(i < 5 ? 5 - i : 0) || sif.tc !== (i == 5) ||
          sif.done !== (i >= 5)) begin
        miscompares++;
        $display("FAIL oneshot_seq[%0d]: count=%0d tc=%b done=%b", i,
                 sif.count, sif.tc, sif.done);
      end
`endif
    end
  endtask

  task automatic test_autoreload();
    drive(1'b0, 1'b1, 1'b1, 3);
    for (int i = 1; i <= 12 * SF; i++) begin
      drive(1'b1, 1'b0, 1'b1, 0);
      vectors++;
      if (sif.count !== W'(m_cnt) || sif.tc !== m_tc ||
          sif.busy !== 1'b1 || sif.done !== 1'b0) begin
        miscompares++;
        $display("FAIL autoreload[%0d]: got %0d/%b/%b want %0d/%b/1",
                 i, sif.count, sif.tc, sif.busy, m_cnt, m_tc);
      end
`ifndef CNT_PRESCALE_EN
      vectors++;
      if (sif.count !== W'(3 - (i % 4)) || sif.tc !== ((i % 4) == 3)) begin
        miscompares++;
        $display("FAIL autoreload_seq[%0d]: count=%0d tc=%b want %0d %b",
                 i, sif.count, sif.tc, 3 - (i % 4), (i % 4) == 3);
      end
`endif
    end
  endtask

  task automatic test_load_at_one();
    int n = 0;
    drive(1'b0, 1'b1, 1'b0, 9);
    while (m_cnt != 1 && n < 200) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      n++;
    end
    vectors++;
    if (n >= 200 || sif.count !== W'(1)) begin
      miscompares++;
      $display("FAIL load_at_one_reach: count=%0d want 1", sif.count);
    end
`ifdef CNT_PRESCALE_EN
    while (m_ps != PS - 1 && n < 400) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      n++;
    end
`endif
    drive(1'b1, 1'b1, 1'b0, 6);
    vectors++;
    if (sif.count !== W'(6) || sif.tc !== 1'b0 ||
        sif.busy !== 1'b1 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_at_one: got %0d/%b/%b/%b want 6/0/1/0",
               sif.count, sif.tc, sif.busy, sif.done);
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    vectors++;
    if (sif.tc !== 1'b0 || sif.count !== W'(m_cnt)) begin
      miscompares++;
      $display("FAIL load_at_one_next: count=%0d tc=%b want %0d 0",
               sif.count, sif.tc, m_cnt);
    end
  endtask

  task automatic test_load_zero();
    drive(1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (sif.count !== '0 || sif.tc !== 1'b0 ||
          sif.busy !== 1'b0 || sif.done !== 1'b0) begin
        miscompares++;
        $display("FAIL load_zero[%0d]: got %0d/%b/%b/%b want 0/0/0/0",
                 i, sif.count, sif.tc, sif.busy, sif.done);
      end
      drive(1'b1, 1'b0, i[0], 0);
    end
  endtask

  task automatic test_en_gaps();
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_c [7] = '{3, 3, 3, 2, 1, 1, 0};
    drive(1'b0, 1'b1, 1'b0, 4);
    for (int r = 0; r < SF; r++) begin
      for (int i = 0; i < 7; i++) begin
        drive(pat[i], 1'b0, 1'b0, 0);
        vectors++;
        if (sif.count !== W'(m_cnt) || sif.tc !== m_tc ||
            sif.done !== m_exp) begin
          miscompares++;
          $display("FAIL en_gaps[%0d]: got %0d/%b/%b want %0d/%b/%b", i,
                   sif.count, sif.tc, sif.done, m_cnt, m_tc, m_exp);
        end
`ifndef CNT_PRESCALE_EN
        vectors++;
        if (sif.count !== W'(exp_c[i]) || sif.tc !== (i == 6)) begin
          miscompares++;
          $display("FAIL en_gaps_seq[%0d]: count=%0d tc=%b want %0d %b",
                   i, sif.count, sif.tc, exp_c[i], i == 6);
        end
`endif
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    vectors++;
    if (sif.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL en_gaps_tc_width: tc=%b want 0", sif.tc);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    drive(1'b0, 1'b1, 1'b0, 15);
    while (sif.count !== W'(8) && n < 200) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      n++;
    end
    vectors++;
    if (n >= 200 || m_cnt != 8 || sif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reach8: count=%0d busy=%b want 8 1",
               sif.count, sif.busy);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (sif.count !== '0 || sif.tc !== 1'b0 ||
        sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %0d/%b/%b/%b want 0/0/0/0",
               sif.count, sif.tc, sif.busy, sif.done);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 0);
    vectors++;
    if (sif.count !== '0 || sif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_after: count=%0d busy=%b want 0 0",
               sif.count, sif.busy);
    end
  endtask

`ifdef CNT_PRESCALE_EN
  task automatic test_prescale();
    drive(1'b0, 1'b1, 1'b0, 2);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      vectors++;
      if (sif.tc !== (i == 8) ||
          sif.count !== W'(i < 4 ? 2 : (i < 8 ? 1 : 0))) begin
        miscompares++;
        $display("FAIL prescale[%0d]: count=%0d tc=%b", i,
                 sif.count, sif.tc);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit e, l, ar;
    int lv;
    ar = 1'b0;
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(0, 99) < 75);
      l  = ($urandom_range(0, 99) < 6);
      lv = $urandom_range(0, (1 << W) - 1);
      if ($urandom_range(0, 9) == 0) ar = ~ar;
      drive(e, l, ar, lv);
      vectors++;
      if (sif.count !== W'(m_cnt) || sif.tc !== m_tc ||
          sif.busy !== m_run || sif.done !== m_exp) begin
        miscompares++;
        $display("FAIL random[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, sif.count, sif.tc, sif.busy, sif.done,
                 m_cnt, m_tc, m_run, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_load_at_one();
    test_load_zero();
    test_en_gaps();
    test_async_reset();
`ifdef CNT_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
